// File: rtl/predecode_stage_v2_if.sv
// Fetch-side input, ibuffer-side output and redirect bundle for predecode_stage_v2.
// out_push/out_pop exist only when PREDECODE_RAS_EN is defined.
interface predecode_stage_v2_if #(
  parameter int SLOTS      = 16,
  parameter int VADDR_SIZE = 39,
  parameter int FSQ_WIDTH  = 5
);
  localparam int SW = $clog2(SLOTS);

  logic                  in_valid;
  logic                  in_ready;
  logic [SLOTS*16-1:0]   in_data;
  logic [SLOTS-1:0]      in_en;
  logic [VADDR_SIZE-1:0] in_start_addr;
  logic [FSQ_WIDTH-1:0]  in_fsq_idx;
  logic                  in_pred_taken;
  logic [SW-1:0]         in_pred_tail;
  logic [VADDR_SIZE-1:0] in_pred_target;

  logic                  out_valid;
  logic                  out_ready;
  logic [SW:0]           out_num;
  logic [SLOTS-1:0]      out_en;
  logic [SLOTS*32-1:0]   out_inst;
  logic [SLOTS*SW-1:0]   out_offset;
  logic                  out_cross;
  logic [FSQ_WIDTH-1:0]  out_fsq_idx;
`ifdef PREDECODE_RAS_EN
  logic [SLOTS-1:0]      out_push;
  logic [SLOTS-1:0]      out_pop;
`endif

  logic                  redir_valid;
  logic [FSQ_WIDTH-1:0]  redir_fsq_idx;
  logic                  redir_taken;
  logic [SW-1:0]         redir_tail;
  logic [VADDR_SIZE-1:0] redir_target;

  modport slave (
    input  in_valid, in_data, in_en, in_start_addr, in_fsq_idx,
           in_pred_taken, in_pred_tail, in_pred_target, out_ready,
    output in_ready, out_valid, out_num, out_en, out_inst, out_offset,
           out_cross, out_fsq_idx,
`ifdef PREDECODE_RAS_EN
           out_push, out_pop,
`endif
           redir_valid, redir_fsq_idx, redir_taken, redir_tail, redir_target
  );

  modport master (
    output in_valid, in_data, in_en, in_start_addr, in_fsq_idx,
           in_pred_taken, in_pred_tail, in_pred_target, out_ready,
    input  in_ready, out_valid, out_num, out_en, out_inst, out_offset,
           out_cross, out_fsq_idx,
`ifdef PREDECODE_RAS_EN
           out_push, out_pop,
`endif
           redir_valid, redir_fsq_idx, redir_taken, redir_tail, redir_target
  );
endinterface

// File: rtl/predecode_stage_v2.sv
// Two-stage RVC/RVI predecoder: stitches split RVI across blocks, compacts, checks FTQ prediction.
// Optional PREDECODE_RAS_EN adds per-instruction out_push/out_pop RAS hints.
module predecode_stage_v2 #(
  parameter int SLOTS      = 16,
  parameter int VADDR_SIZE = 39,
  parameter int FSQ_WIDTH  = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  predecode_stage_v2_if.slave bus
);
  localparam int SW = $clog2(SLOTS);
  typedef logic [VADDR_SIZE-1:0] addr_t;

  logic                 s1_valid_q, s1_ptaken_q, carry_valid_q;
  logic [SLOTS*16-1:0]  s1_data_q;
  logic [SLOTS-1:0]     s1_en_q;
  addr_t                s1_start_q, s1_ptgt_q, carry_addr_q, redir_target_q;
  logic [FSQ_WIDTH-1:0] s1_fsq_q, out_fsq_q, redir_fsq_q;
  logic [SW-1:0]        s1_ptail_q, redir_tail_q;
  logic [15:0]          carry_half_q;
  logic                 out_valid_q, out_cross_q, redir_valid_q, redir_taken_q;
  logic [SW:0]          out_num_q;
  logic [SLOTS-1:0]     out_en_q;
  logic [SLOTS*32-1:0]  out_inst_q;
  logic [SLOTS*SW-1:0]  out_offset_q;

  logic s1_adv, s2_load;
  assign s1_adv       = ~out_valid_q | bus.out_ready;
  assign s2_load      = s1_valid_q & s1_adv;
  assign bus.in_ready = ~s1_valid_q | s1_adv;

  logic [(SLOTS+1)*16-1:0] data_x;
  logic [SLOTS:0]          en_x;
  logic                    carry_hit;
  logic [SLOTS-1:0]        start, iv, dangle, djump, brcls;
  logic [31:0]             inst [SLOTS];
  addr_t                   tgt  [SLOTS];
`ifdef PREDECODE_RAS_EN
  logic [SLOTS-1:0]        push, pop, push_c, pop_c, out_push_q, out_pop_q;

  function automatic logic is_link(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction
`endif

  // Slot 0 holds the upper half of a stitched RVI when the carry hits; its pc is start-2.
  always_comb begin
    logic        cont, rvi, is_jal, is_jalr, is_bcc, is_cj, is_cjal, is_cb, is_cjr_any;
    logic [31:0] x;
    addr_t       pc, jimm, cimm;
    data_x    = {16'h0, s1_data_q};
    en_x      = {1'b0, s1_en_q};
    carry_hit = carry_valid_q & s1_en_q[0] & (s1_start_q == carry_addr_q + addr_t'(2));
    cont      = carry_hit;
    for (int unsigned i = 0; i < SLOTS; i++) begin
      rvi       = data_x[16*i +: 2] == 2'b11;
      start[i]  = en_x[i] & ~cont;
      dangle[i] = start[i] & rvi & ~en_x[i+1];
      if (i == 0 && carry_hit) begin
        iv[i]   = 1'b1;
        inst[i] = {data_x[15:0], carry_half_q};
        pc      = s1_start_q - addr_t'(2);
      end else begin
        iv[i]   = start[i] & (~rvi | en_x[i+1]);
        inst[i] = rvi ? data_x[16*i +: 32] : {16'h0, data_x[16*i +: 16]};
        pc      = s1_start_q + addr_t'(2*i);
      end
      cont       = start[i] & rvi;
      x          = inst[i];
      is_jal     = x[6:0] == 7'h6f;
      is_jalr    = (x[6:0] == 7'h67) && (x[14:12] == 3'b000);
      is_bcc     = x[6:0] == 7'h63;
      is_cj      = (x[1:0] == 2'b01) && (x[15:13] == 3'b101);
      is_cjal    = (x[1:0] == 2'b01) && (x[15:13] == 3'b001);
      is_cb      = (x[1:0] == 2'b01) && (x[15:14] == 2'b11);
      is_cjr_any = (x[1:0] == 2'b10) && (x[15:13] == 3'b100) && (x[11:7] != 5'd0) && (x[6:2] == 5'd0);
      jimm = {{(VADDR_SIZE-21){x[31]}}, x[31], x[19:12], x[20], x[30:21], 1'b0};
      cimm = {{(VADDR_SIZE-12){x[12]}}, x[12], x[8], x[10:9], x[6], x[7], x[2], x[11], x[5:3], 1'b0};
      tgt[i]   = pc + (is_jal ? jimm : cimm);
      djump[i] = iv[i] & (is_jal | is_cj | is_cjal);
      brcls[i] = iv[i] & (is_jal | is_jalr | is_bcc | is_cj | is_cjal | is_cb | is_cjr_any);
`ifdef PREDECODE_RAS_EN
      push[i] = iv[i] & (((is_jal | is_jalr) & is_link(x[11:7])) | is_cjal | (is_cjr_any & x[12]));
      pop[i]  = iv[i] & ((is_jalr & is_link(x[19:15]) & (~is_link(x[11:7]) | (x[11:7] != x[19:15])))
                       | (is_cjr_any & ~x[12] & is_link(x[11:7])));
`endif
    end
  end

  logic                found, redir_a, redir_b, redir_any, carry_set;
  logic [SW-1:0]       jslot, last;
  logic [SW:0]         num_c;
  logic [SLOTS-1:0]    en_c;
  logic [SLOTS*32-1:0] inst_c;
  logic [SLOTS*SW-1:0] off_c;

  always_comb begin
    int unsigned k;
    found = 1'b0;
    jslot = '0;
    last  = '0;
    for (int unsigned i = 0; i < SLOTS; i++) begin
      if (djump[i] && !found) begin
        found = 1'b1;
        jslot = SW'(i);
      end
      if (s1_en_q[i]) last = SW'(i);
    end
    redir_a   = found & (~s1_ptaken_q | (s1_ptail_q != jslot) | (s1_ptgt_q != tgt[jslot]));
    redir_b   = ~redir_a & s1_ptaken_q & ~brcls[s1_ptail_q];
    redir_any = redir_a | redir_b;
    carry_set = dangle[last] & ~redir_any;
    k      = 0;
    inst_c = '0;
    off_c  = '0;
`ifdef PREDECODE_RAS_EN
    push_c = '0;
    pop_c  = '0;
`endif
    for (int unsigned i = 0; i < SLOTS; i++) begin
      if (iv[i] && (!redir_a || SW'(i) <= jslot)) begin
        inst_c[32*k +: 32] = inst[i];
        off_c[SW*k +: SW]  = SW'(i);
`ifdef PREDECODE_RAS_EN
        push_c[k] = push[i];
        pop_c[k]  = pop[i];
`endif
        k++;
      end
    end
    num_c = (SW+1)'(k);
    for (int unsigned i = 0; i < SLOTS; i++) en_c[i] = i < k;
  end

  // A redirect discards whatever S1 accepts on the same edge, and any pending carry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q <= 1'b0; s1_data_q <= '0; s1_en_q <= '0; s1_start_q <= '0;
      s1_fsq_q <= '0; s1_ptaken_q <= 1'b0; s1_ptail_q <= '0; s1_ptgt_q <= '0;
      carry_valid_q <= 1'b0; carry_half_q <= '0; carry_addr_q <= '0;
      out_valid_q <= 1'b0; out_num_q <= '0; out_en_q <= '0; out_inst_q <= '0;
      out_offset_q <= '0; out_cross_q <= 1'b0; out_fsq_q <= '0;
      redir_valid_q <= 1'b0; redir_fsq_q <= '0; redir_taken_q <= 1'b0;
      redir_tail_q <= '0; redir_target_q <= '0;
`ifdef PREDECODE_RAS_EN
      out_push_q <= '0; out_pop_q <= '0;
`endif
    end else if (flush) begin
      s1_valid_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      carry_valid_q <= 1'b0;
      redir_valid_q <= 1'b0;
    end else begin
      redir_valid_q <= 1'b0;
      if (s1_adv) out_valid_q <= s1_valid_q;
      if (s2_load) begin
        out_num_q     <= num_c;
        out_en_q      <= en_c;
        out_inst_q    <= inst_c;
        out_offset_q  <= off_c;
        out_cross_q   <= carry_hit;
        out_fsq_q     <= s1_fsq_q;
`ifdef PREDECODE_RAS_EN
        out_push_q    <= push_c;
        out_pop_q     <= pop_c;
`endif
        carry_valid_q <= carry_set;
        if (carry_set) begin
          carry_half_q <= s1_data_q[16*last +: 16];
          carry_addr_q <= s1_start_q + addr_t'({last, 1'b0});
        end
        if (redir_any) begin
          redir_valid_q  <= 1'b1;
          redir_fsq_q    <= s1_fsq_q;
          redir_taken_q  <= redir_a;
          redir_tail_q   <= redir_a ? jslot : last;
          redir_target_q <= redir_a ? tgt[jslot] : s1_start_q + addr_t'(2*SLOTS);
        end
      end
      if (s2_load && redir_any) s1_valid_q <= 1'b0;
      else if (bus.in_ready)    s1_valid_q <= bus.in_valid;
      if (bus.in_valid && bus.in_ready) begin
        s1_data_q   <= bus.in_data;
        s1_en_q     <= bus.in_en;
        s1_start_q  <= bus.in_start_addr;
        s1_fsq_q    <= bus.in_fsq_idx;
        s1_ptaken_q <= bus.in_pred_taken;
        s1_ptail_q  <= bus.in_pred_tail;
        s1_ptgt_q   <= bus.in_pred_target;
      end
    end
  end

  assign bus.out_valid     = out_valid_q;
  assign bus.out_num       = out_num_q;
  assign bus.out_en        = out_en_q;
  assign bus.out_inst      = out_inst_q;
  assign bus.out_offset    = out_offset_q;
  assign bus.out_cross     = out_cross_q;
  assign bus.out_fsq_idx   = out_fsq_q;
  assign bus.redir_valid   = redir_valid_q;
  assign bus.redir_fsq_idx = redir_fsq_q;
  assign bus.redir_taken   = redir_taken_q;
  assign bus.redir_tail    = redir_tail_q;
  assign bus.redir_target  = redir_target_q;
`ifdef PREDECODE_RAS_EN
  assign bus.out_push      = out_push_q;
  assign bus.out_pop       = out_pop_q;
`endif
endmodule

// File: tb/tb_predecode_stage_v2.sv
// Directed bench for predecode_stage_v2: reset, compaction, split-RVI stitch, redirects,
// backpressure/flush and asynchronous reset mid-stream, with hand-computed expectations.
module tb_predecode_stage_v2;
  logic clk, rst, flush;
  int   checks, errors;
  logic [15:0] hw [16];

  predecode_stage_v2_if #(.SLOTS(16), .VADDR_SIZE(39), .FSQ_WIDTH(5)) bus ();

  predecode_stage_v2 #(.SLOTS(16), .VADDR_SIZE(39), .FSQ_WIDTH(5)) dut (
    .clk  (clk),
    .rst  (rst),
    .flush(flush),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] cli(input int s);
    return 16'h4501 + 16'(4*s);
  endfunction

  function automatic logic [31:0] ent(input int k);
    return bus.out_inst[32*k +: 32];
  endfunction

  function automatic logic [3:0] off(input int k);
    return bus.out_offset[4*k +: 4];
  endfunction

  task automatic fill_cli();
    for (int s = 0; s < 16; s++) hw[s] = cli(s);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one block and returns #1 after the edge that accepted it.
  task automatic send(input logic [38:0] start, input logic [15:0] en, input logic pt,
                      input logic [3:0] ptl, input logic [38:0] ptg, input logic [4:0] fsq);
    int n;
    n = 0;
    for (int i = 0; i < 16; i++) bus.in_data[16*i +: 16] = hw[i];
    bus.in_en          = en;
    bus.in_start_addr  = start;
    bus.in_pred_taken  = pt;
    bus.in_pred_tail   = ptl;
    bus.in_pred_target = ptg;
    bus.in_fsq_idx     = fsq;
    bus.in_valid       = 1'b1;
    while (!bus.in_ready && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) check("accept_timeout", 64'(n), 0);
    step();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_en = '0;
    bus.in_start_addr = '0;
    bus.in_fsq_idx = '0;
    bus.in_pred_taken = 1'b0;
    bus.in_pred_tail = '0;
    bus.in_pred_target = '0;
    bus.out_ready = 1'b1;
    #12;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_redir_valid", bus.redir_valid, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_num", bus.out_num, 0);
    check("rst_inst0", ent(0), 0);
    rst = 1'b1;
    step();

    // 4 RVI + 8 RVC compaction
    for (int w = 0; w < 4; w++) begin
      hw[2*w]   = 16'h0513;
      hw[2*w+1] = 16'((w+1)*16);
    end
    for (int s = 8; s < 16; s++) hw[s] = cli(s);
    send(39'h1000, 16'hFFFF, 1'b0, 4'd0, 39'h0, 5'd3);
    check("lat_s1_only", bus.out_valid, 0);
    step();
    check("cmp_valid", bus.out_valid, 1);
    check("cmp_num", bus.out_num, 12);
    check("cmp_en", bus.out_en, 16'h0FFF);
    check("cmp_redir", bus.redir_valid, 0);
    check("cmp_cross", bus.out_cross, 0);
    check("cmp_fsq", bus.out_fsq_idx, 3);
    for (int k = 0; k < 4; k++) begin
      check("cmp_rvi_inst", ent(k), {16'((k+1)*16), 16'h0513});
      check("cmp_rvi_off", off(k), 64'(2*k));
    end
    for (int k = 4; k < 12; k++) begin
      check("cmp_rvc_inst", ent(k), {16'h0, cli(k+4)});
      check("cmp_rvc_off", off(k), 64'(k+4));
    end
    check("cmp_zero12", ent(12), 0);
    check("cmp_zero15", ent(15), 0);

    // Split RVI stitched into the sequential next block
    fill_cli();
    hw[15] = 16'h0513;
    send(39'h1000, 16'hFFFF, 1'b0, 4'd0, 39'h0, 5'd4);
    step();
    check("splitA_num", bus.out_num, 15);
    check("splitA_en", bus.out_en, 16'h7FFF);
    check("splitA_redir", bus.redir_valid, 0);
    fill_cli();
    hw[0] = 16'h0050;
    send(39'h1020, 16'hFFFF, 1'b0, 4'd0, 39'h0, 5'd5);
    step();
    check("splitB_cross", bus.out_cross, 1);
    check("splitB_num", bus.out_num, 16);
    check("splitB_inst0", ent(0), 32'h00500513);
    check("splitB_off0", off(0), 0);
    check("splitB_inst1", ent(1), {16'h0, cli(1)});
    check("splitB_off15", off(15), 15);
    check("splitB_redir", bus.redir_valid, 0);

    // Same half, but the next block is non-sequential
    fill_cli();
    hw[15] = 16'h0513;
    send(39'h1000, 16'hFFFF, 1'b0, 4'd0, 39'h0, 5'd4);
    step();
    check("splitA2_num", bus.out_num, 15);
    fill_cli();
    send(39'h2000, 16'hFFFF, 1'b0, 4'd0, 39'h0, 5'd5);
    step();
    check("nonseq_cross", bus.out_cross, 0);
    check("nonseq_num", bus.out_num, 16);
    check("nonseq_inst0", ent(0), {16'h0, cli(0)});
    check("nonseq_redir", bus.redir_valid, 0);

    // c.j at slot 3 (pc 0x1006, target 0x1040) correctly predicted
    fill_cli();
    hw[3] = 16'hA82D;
    send(39'h1000, 16'hFFFF, 1'b1, 4'd3, 39'h1040, 5'd6);
    step();
    check("goodpred_redir", bus.redir_valid, 0);
    check("goodpred_num", bus.out_num, 16);

    // Same c.j not predicted; the block queued behind it must vanish
    send(39'h1000, 16'hFFFF, 1'b0, 4'd0, 39'h0, 5'd7);
    send(39'h1020, 16'hFFFF, 1'b0, 4'd0, 39'h0, 5'd8);
    check("miss_valid", bus.out_valid, 1);
    check("miss_redir", bus.redir_valid, 1);
    check("miss_taken", bus.redir_taken, 1);
    check("miss_tail", bus.redir_tail, 3);
    check("miss_target", bus.redir_target, 39'h1040);
    check("miss_rfsq", bus.redir_fsq_idx, 7);
    check("miss_num", bus.out_num, 4);
    check("miss_en", bus.out_en, 16'h000F);
    check("miss_inst3", ent(3), 32'h0000A82D);
    check("miss_zero4", ent(4), 0);
    step();
    check("miss_pulse", bus.redir_valid, 0);
    check("miss_dropped", bus.out_valid, 0);
    step();
    check("miss_dropped2", bus.out_valid, 0);
    check("miss_in_ready", bus.in_ready, 1);

    // Predicted taken on a non-branch, partially enabled block
    fill_cli();
    send(39'h3000, 16'h00FF, 1'b1, 4'd5, 39'h3100, 5'd9);
    step();
    check("ft_redir", bus.redir_valid, 1);
    check("ft_taken", bus.redir_taken, 0);
    check("ft_tail", bus.redir_tail, 7);
    check("ft_target", bus.redir_target, 39'h3020);
    check("ft_num", bus.out_num, 8);
    check("ft_en", bus.out_en, 16'h00FF);
    check("ft_fsq", bus.redir_fsq_idx, 9);
    step();
    check("ft_pulse", bus.redir_valid, 0);

    // Backpressure, then flush drops outputs, S1 and the pending carry
    bus.out_ready = 1'b0;
    fill_cli();
    hw[15] = 16'h0513;
    send(39'h4000, 16'hFFFF, 1'b0, 4'd0, 39'h0, 5'd10);
    fill_cli();
    send(39'h5000, 16'hFFFF, 1'b0, 4'd0, 39'h0, 5'd11);
    check("bp_valid", bus.out_valid, 1);
    check("bp_in_ready", bus.in_ready, 0);
    check("bp_num", bus.out_num, 15);
    for (int c = 0; c < 5; c++) begin
      step();
      check("bp_hold_valid", bus.out_valid, 1);
      check("bp_hold_num", bus.out_num, 15);
      check("bp_hold_fsq", bus.out_fsq_idx, 10);
      check("bp_hold_inst0", ent(0), {16'h0, cli(0)});
      check("bp_hold_ready", bus.in_ready, 0);
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_valid", bus.out_valid, 0);
    check("flush_in_ready", bus.in_ready, 1);
    check("flush_redir", bus.redir_valid, 0);
    bus.out_ready = 1'b1;
    fill_cli();
    hw[0] = 16'h0050;
    send(39'h4020, 16'hFFFF, 1'b0, 4'd0, 39'h0, 5'd12);
    step();
    check("postflush_valid", bus.out_valid, 1);
    check("postflush_cross", bus.out_cross, 0);
    check("postflush_num", bus.out_num, 16);
    check("postflush_inst0", ent(0), 32'h00000050);
    check("postflush_fsq", bus.out_fsq_idx, 12);

    // Asynchronous reset while a block is held at the output
    bus.out_ready = 1'b0;
    fill_cli();
    send(39'h6000, 16'hFFFF, 1'b0, 4'd0, 39'h0, 5'd13);
    step();
    check("arst_pre_valid", bus.out_valid, 1);
    #2;
    rst = 1'b0;
    #1;
    check("arst_valid", bus.out_valid, 0);
    check("arst_num", bus.out_num, 0);
    check("arst_in_ready", bus.in_ready, 1);
    #2;
    rst = 1'b1;
    step();
    bus.out_ready = 1'b1;
    send(39'h7000, 16'hFFFF, 1'b0, 4'd0, 39'h0, 5'd14);
    check("arst_lat_s1", bus.out_valid, 0);
    step();
    check("arst_lat_out", bus.out_valid, 1);
    check("arst_num_after", bus.out_num, 16);
    check("arst_fsq_after", bus.out_fsq_idx, 14);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
